// File: rtl/xnor_cmp_sched_pkg.sv
// xnor_ctrl_pkg: shared state encoding and width helpers for the XNOR compare scheduler
package xnor_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int cycles_of(input int w, input int l);
    return w / l;
  endfunction
  function automatic int idw_of(input int n);
    return clog2(n);
  endfunction
  function automatic int cw_of(input int w);
    return clog2(w + 1);
  endfunction
endpackage

// File: rtl/xnor_cmp_sched_if.sv
// xnor_cmp_sched_if: requester-side request/operand bus and result bus of the scheduler
interface xnor_cmp_sched_if import xnor_ctrl_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = idw_of(N_REQ);
  localparam int CW = cw_of(WIDTH);
  logic [N_REQ-1:0] req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0] gnt;
  logic busy;
  logic res_valid;
  logic [IDW-1:0] res_id;
  logic [WIDTH-1:0] res_xnor;
  logic [CW-1:0] res_match;
  logic res_eq;
  modport master (
    output req, a_in, b_in,
    input gnt, busy, res_valid, res_id, res_xnor, res_match, res_eq
  );
  modport slave (
    input req, a_in, b_in,
    output gnt, busy, res_valid, res_id, res_xnor, res_match, res_eq
  );
endinterface

// File: rtl/xnor_cmp_sched_rr_pick.sv
// rr_pick: combinational round-robin selector, first requester at or after ptr with wrap
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             any_req,
  output logic [IDW-1:0]   sel_id
);
  logic [N_REQ-1:0] rot;
  logic [IDW-1:0] off;
  logic [IDW:0] sum;
  always_comb begin
    any_req = |req;
    rot = N_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) off = rot[i] ? IDW'(i) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    sel_id = IDW'(sum >= (IDW+1)'(N_REQ) ? sum - (IDW+1)'(N_REQ) : sum);
  end
endmodule

// File: rtl/xnor_cmp_sched.sv
// xnor_cmp_sched: round-robin shared bit-sliced XNOR compare with popcount, LSB-first lanes
module xnor_cmp_sched import xnor_ctrl_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int LANES = 2
) (
  input logic clk,
  input logic rst,
  xnor_cmp_sched_if.slave bus
);
  localparam int CYCLES = cycles_of(WIDTH, LANES);
  localparam int IDW = idw_of(N_REQ);
  localparam int CW = cw_of(WIDTH);
  localparam int BW = cw_of(CYCLES);
  if (WIDTH % LANES != 0) begin : g_bad_lanes
    $error("WIDTH must be a multiple of LANES");
  end
  state_t state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_n;
  logic [CW-1:0] cnt, cnt_n, lane_cnt;
  logic [LANES-1:0] lane;
  logic [BW-1:0] beat;
  logic [IDW-1:0] ptr, id, sel_id;
  logic any_req, last;
  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req(bus.req),
    .ptr(ptr),
    .any_req(any_req),
    .sel_id(sel_id)
  );
  always_comb begin
    lane = ~(a_sh[LANES-1:0] ^ b_sh[LANES-1:0]);
    lane_cnt = '0;
    for (int k = 0; k < LANES; k++) lane_cnt = lane_cnt + CW'(lane[k]);
    acc_n = acc | (WIDTH'(lane) << (int'(beat) * LANES));
    cnt_n = cnt + lane_cnt;
    last = beat == BW'(CYCLES - 1);
    state_n = state == IDLE ? (any_req ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      acc <= '0;
      cnt <= '0;
      beat <= '0;
      id <= '0;
      ptr <= '0;
      bus.gnt <= '0;
      bus.res_valid <= 1'b0;
      bus.res_id <= '0;
      bus.res_xnor <= '0;
      bus.res_match <= '0;
      bus.res_eq <= 1'b0;
    end else begin
      bus.gnt <= '0;
      bus.res_valid <= 1'b0;
      if (state == IDLE && any_req) begin
        a_sh <= WIDTH'(bus.a_in >> (int'(sel_id) * WIDTH));
        b_sh <= WIDTH'(bus.b_in >> (int'(sel_id) * WIDTH));
        id <= sel_id;
        beat <= '0;
        acc <= '0;
        cnt <= '0;
        bus.gnt <= N_REQ'(1) << sel_id;
      end
      if (state == RUN) begin
        a_sh <= a_sh >> LANES;
        b_sh <= b_sh >> LANES;
        acc <= acc_n;
        cnt <= cnt_n;
        beat <= beat + 1'b1;
        if (last) begin
          bus.res_valid <= 1'b1;
          bus.res_id <= id;
          bus.res_xnor <= acc_n;
          bus.res_match <= cnt_n;
          bus.res_eq <= cnt_n == CW'(WIDTH);
        end
      end
      if (state == DONE) ptr <= id == IDW'(N_REQ - 1) ? '0 : id + 1'b1;
    end
  end
endmodule

// File: tb/tb_xnor_cmp_sched.sv
// tb_xnor_cmp_sched: scoreboard bench for the round-robin XNOR compare scheduler
module tb_xnor_cmp_sched;
  localparam int N = 4;
  localparam int W = 8;
  typedef struct {
    logic [1:0] id;
    logic [7:0] x;
    logic [3:0] m;
    logic eq;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  exp_t sb[$];
  xnor_cmp_sched_if #(.N_REQ(N), .WIDTH(W)) bus();
  xnor_cmp_sched #(.N_REQ(N), .WIDTH(W), .LANES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.res_valid) begin
      exp_t e;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL res_unexpected got id=%0d xnor=%h match=%0d", bus.res_id, bus.res_xnor, bus.res_match);
      end else begin
        e = sb.pop_front();
        if (bus.res_id !== e.id || bus.res_xnor !== e.x || bus.res_match !== e.m || bus.res_eq !== e.eq) begin
          n_fail++;
          $display("FAIL result got id=%0d xnor=%h match=%0d eq=%b want id=%0d xnor=%h match=%0d eq=%b",
                   bus.res_id, bus.res_xnor, bus.res_match, bus.res_eq, e.id, e.x, e.m, e.eq);
        end
      end
    end
  end

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
    bus.a_in[id*W +: W] = a;
    bus.b_in[id*W +: W] = b;
  endtask

  task automatic push_exp(input int id, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.id = 2'(id);
    e.x = ~(a ^ b);
    e.m = 4'($countones(e.x));
    e.eq = e.m == 4'd8;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(output logic [3:0] g, output int at);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0) begin
        g = bus.gnt;
        at = cyc;
        return;
      end
    end
    g = 4'b0;
    at = -1;
  endtask

  task automatic wait_done(output bit ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        return;
      end
    end
    ok = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] g;
    int at;
    bit ok;
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_ops(i, 8'h10 + 8'(i), 8'h13);
    bus.req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_id !== 2'd0 ||
          bus.res_xnor !== 8'h00 || bus.res_match !== 4'd0 || bus.res_eq !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs got gnt=%b busy=%b rv=%b id=%0d x=%h m=%0d eq=%b want all 0",
                 bus.gnt, bus.busy, bus.res_valid, bus.res_id, bus.res_xnor, bus.res_match, bus.res_eq);
      end
    end
    push_exp(0, 8'h10, 8'h13);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_gnt(g, at);
    bus.req = '0;
    n_tests++;
    if (g !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_gnt got %b want 0001", g);
    end
    wait_done(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_job_done got timeout want completion");
    end
  endtask

  task automatic test_single();
    logic [3:0] g;
    int at, busy_n, rv_at;
    bit ok;
    set_ops(0, 8'hA5, 8'hA5);
    push_exp(0, 8'hA5, 8'hA5);
    bus.req = 4'b0001;
    wait_gnt(g, at);
    bus.req = '0;
    n_tests++;
    if (g !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_gnt got %b want 0001", g);
    end
    busy_n = 0;
    rv_at = -1;
    for (int n = 0; n < 7; n++) begin
      if (n > 0) @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.res_valid) rv_at = n;
      n_tests++;
      if (n > 0 && bus.gnt !== 4'b0) begin
        n_fail++;
        $display("FAIL single_gnt_pulse got %b at +%0d want 0000", bus.gnt, n);
      end
    end
    n_tests++;
    if (busy_n != 5) begin
      n_fail++;
      $display("FAIL single_busy_cycles got %0d want 5", busy_n);
    end
    n_tests++;
    if (rv_at != 4) begin
      n_fail++;
      $display("FAIL single_latency got %0d want 4", rv_at);
    end
    wait_done(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_done got timeout want completion");
    end
  endtask

  task automatic test_values();
    logic [7:0] av[2] = '{8'hF0, 8'hA5};
    logic [7:0] bv[2] = '{8'h0F, 8'hA4};
    logic [3:0] g;
    int at;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      set_ops(1, av[k], bv[k]);
      push_exp(1, av[k], bv[k]);
      bus.req = 4'b0010;
      wait_gnt(g, at);
      bus.req = '0;
      n_tests++;
      if (g !== 4'b0010) begin
        n_fail++;
        $display("FAIL values_gnt%0d got %b want 0010", k, g);
      end
      wait_done(ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL values_done%0d got timeout want completion", k);
      end
    end
  endtask

  task automatic test_back_to_back();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] g;
    int at, prev;
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 8'h3C ^ 8'(i * 17), 8'h3C);
    for (int k = 0; k < 5; k++) push_exp(order[k], 8'h3C ^ 8'(order[k] * 17), 8'h3C);
    bus.req = 4'hF;
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g, at);
      n_tests++;
      if (g !== 4'(1 << order[k])) begin
        n_fail++;
        $display("FAIL rr_gnt%0d got %b want %b", k, g, 4'(1 << order[k]));
      end
      if (k > 0) begin
        n_tests++;
        if (at - prev != 6) begin
          n_fail++;
          $display("FAIL rr_spacing%0d got %0d want 6", k, at - prev);
        end
      end
      prev = at;
      bus.req[order[k]] = 1'b0;
      @(negedge clk);
      bus.req[order[k]] = 1'b1;
    end
    bus.req = '0;
    wait_done(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rr_done got timeout want completion");
    end
  endtask

  task automatic test_wrap();
    logic [3:0] g;
    int at;
    bit ok;
    set_ops(3, 8'h81, 8'h7E);
    push_exp(3, 8'h81, 8'h7E);
    bus.req = 4'b1000;
    wait_gnt(g, at);
    bus.req = '0;
    n_tests++;
    if (g !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_gnt3 got %b want 1000", g);
    end
    wait_done(ok);
    set_ops(0, 8'hC3, 8'hC3);
    set_ops(2, 8'h66, 8'h06);
    push_exp(0, 8'hC3, 8'hC3);
    push_exp(2, 8'h66, 8'h06);
    bus.req = 4'b0101;
    wait_gnt(g, at);
    bus.req[0] = 1'b0;
    n_tests++;
    if (g !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_gnt0 got %b want 0001", g);
    end
    wait_gnt(g, at);
    bus.req = '0;
    n_tests++;
    if (g !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_gnt2 got %b want 0100", g);
    end
    wait_done(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wrap_done got timeout want completion");
    end
  endtask

  task automatic test_reset_abort();
    logic [3:0] g;
    int at;
    bit ok;
    set_ops(2, 8'h5A, 8'h5A);
    bus.req = 4'b0100;
    wait_gnt(g, at);
    bus.req = '0;
    n_tests++;
    if (g !== 4'b0100) begin
      n_fail++;
      $display("FAIL abort_gnt got %b want 0100", g);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_id !== 2'd0 || bus.res_xnor !== 8'h00 ||
        bus.res_match !== 4'd0 || bus.res_eq !== 1'b0 || bus.gnt !== 4'b0) begin
      n_fail++;
      $display("FAIL abort_outputs got busy=%b rv=%b id=%0d x=%h m=%0d eq=%b gnt=%b want all 0",
               bus.busy, bus.res_valid, bus.res_id, bus.res_xnor, bus.res_match, bus.res_eq, bus.gnt);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    set_ops(1, 8'h0F, 8'h0E);
    push_exp(1, 8'h0F, 8'h0E);
    bus.req = 4'b0110;
    wait_gnt(g, at);
    bus.req = '0;
    n_tests++;
    if (g !== 4'b0010) begin
      n_fail++;
      $display("FAIL abort_next_gnt got %b want 0010", g);
    end
    wait_done(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL abort_next_done got timeout want completion");
    end
  endtask

  initial begin
    bus.req = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    test_reset();
    test_single();
    test_values();
    test_back_to_back();
    test_wrap();
    test_reset_abort();
    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left got %0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/xnor_cmp_sched.md
Name: xnor_cmp_sched

Overview:
Round-robin scheduler that shares one bit-sliced XNOR compare datapath between N_REQ requesters. The winning requester's operand pair is latched and streamed through LANES XNOR slices per cycle, LSB first. The block accumulates the bitwise XNOR vector and the match count (popcount), then reports the result once with the requester ID. It sits between the requesting units and the shared XNOR compare resource.

Parameters:
N_REQ, 4, number of requesters (≥2)
WIDTH, 8, operand width in bits
LANES, 2, XNOR slices evaluated per cycle; WIDTH % LANES == 0 required
CYCLES (localparam), WIDTH/LANES, RUN cycles per job
IDW (localparam), clog2(N_REQ), requester ID width
CW (localparam), clog2(WIDTH+1), match count width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request level; must stay high until that requester's gnt bit is seen
a_in  in  N_REQ*WIDTH  operand A, requester i in slice [i*WIDTH +: WIDTH]
b_in  in  N_REQ*WIDTH  operand B, same packing as a_in
gnt  out  N_REQ  one-hot, one-cycle grant pulse
busy  out  1  high in RUN and DONE
res_valid  out  1  one-cycle result strobe
res_id  out  IDW  ID of the requester whose result is presented
res_xnor  out  WIDTH  bitwise ~(a^b) of the granted operands
res_match  out  CW  popcount of res_xnor
res_eq  out  1  high when res_match == WIDTH

Behaviour:
- Reset: all outputs 0. State = IDLE. RR pointer = 0. Internal shift registers and accumulators = 0. Reset mid-job aborts the job with no res_valid.
- States: IDLE, RUN, DONE.
- IDLE, any req high at edge k:
  - Select the first requester at or after ptr, wrapping N_REQ-1 → 0.
  - Capture its a/b slices and ID. Go to RUN with beat counter = 0.
  - gnt[i] is registered and high only in cycle k+1.
- IDLE, no req: remain in IDLE.
- RUN:
  - Each cycle, XNOR the low LANES bits of the shifted A/B registers.
  - Place those LANES result bits into the xnor accumulator at position beat*LANES.
  - Add their popcount to the match count. Shift A/B right by LANES.
  - After CYCLES beats go to DONE. RUN occupies cycles k+1 .. k+CYCLES.
- DONE (cycle k+CYCLES+1):
  - res_valid = 1. res_id, res_xnor, res_match, res_eq are updated at the edge entering DONE.
  - ptr = granted ID + 1, with wrap. Next state = IDLE.
- Result outputs hold their last values until the next DONE. res_valid is high for exactly one cycle.
- req is ignored during RUN and DONE. A request dropped before grant is never served.
- Steady state: each job takes 1 IDLE + CYCLES RUN + 1 DONE = CYCLES+2 cycles. Grant-to-res_valid latency = CYCLES cycles.
- Arithmetic: match count is unsigned CW bits and cannot overflow, since its maximum is WIDTH.

Decomposition:
- Shared package xnor_ctrl_pkg: state encoding (IDLE=0, RUN=1, DONE=2), clog2 function, CYCLES/IDW/CW derivations.
- Sub-module rr_pick: combinational round-robin selector. Inputs: req vector and ptr. Outputs: any_req, sel_id. Verified standalone for wrap-around.

Test Plan:
- Reset: hold rst 3 cycles with all req high → gnt=0, busy=0, res_valid=0, res_*=0; first grant goes to requester 0.
- req[0] only, a=8'hA5, b=8'hA5 → gnt=4'b0001 one cycle; busy for 5 cycles; res_valid 4 cycles after gnt with res_id=0, res_xnor=8'hFF, res_match=8, res_eq=1.
- req[1], a=8'hF0, b=8'h0F → res_xnor=8'h00, res_match=0, res_eq=0. Then req[1], a=8'hA5, b=8'hA4 → res_xnor=8'hFE, res_match=7, res_eq=0.
- All four req held high, each requester dropping its req for 1 cycle after its gnt → grants in order 0,1,2,3,0; gnt pulses exactly 6 cycles apart; res_id tracks grant order.
- Wrap-around: after requester 3 is served, assert req[0] and req[2] together → requester 0 granted first (ptr=0), then requester 2.
- Assert rst at the second RUN cycle of a job for requester 2 → no res_valid, outputs return to 0; next req[1]&req[2] grants requester 1 (ptr reset to 0).
